// File: rtl/id_ex_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_reg_pkg
// Shared widths, record layouts and reset constants for the ID/EX pipeline
// register. The record is split into a control group and a data group so that
// each group maps onto one pipe_reg bank.
// -----------------------------------------------------------------------------
package id_ex_reg_pkg;

  localparam int DATA_W  = 16;
  localparam int ALUOP_W = 3;

  // Control bits travelling with the instruction.
  typedef struct packed {
    logic               reg_write;
    logic               alu_src;
    logic               mem_write;
    logic               mem_read;
    logic               reg_store;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // Data fields travelling with the instruction.
  typedef struct packed {
    logic [DATA_W-1:0] pc_p2;
    logic [DATA_W-1:0] arg1;
    logic [DATA_W-1:0] arg2;
    logic [DATA_W-1:0] arg3;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [DATA_W-1:0] rd;
  } data_t;

  localparam int CTRL_W     = $bits(ctrl_t);
  localparam int DATA_REC_W = $bits(data_t);

  // All-zero reset values per field kind.
  localparam logic               BIT_RST   = 1'b0;
  localparam logic [ALUOP_W-1:0] ALUOP_RST = 3'b000;
  localparam logic [DATA_W-1:0]  DATA_RST  = 16'h0000;

  localparam ctrl_t CTRL_RST = ctrl_t'({BIT_RST, BIT_RST, BIT_RST, BIT_RST,
                                        BIT_RST, ALUOP_RST});
  localparam data_t DREC_RST = data_t'({8{DATA_RST}});

endpackage

// File: rtl/id_ex_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_reg_if
// Bundle of the ID-side inputs (I*, RegWrite) and EX-side outputs (O*) of the
// ID/EX pipeline register.
//   master : drives I* and RegWrite, observes O*   (ID stage / testbench)
//   slave  : receives I* and RegWrite, drives O*   (id_ex_reg)
// -----------------------------------------------------------------------------
interface id_ex_reg_if;
  import id_ex_reg_pkg::*;

  logic               RegWrite;

  logic               IRegWrite, IALUSrc, IMemWrite, IMemRead, IRegStore;
  logic [ALUOP_W-1:0] IALUOP;
  logic [DATA_W-1:0]  IPCP2, I1stArg, I2ndArg, I3rdArg, IImm, IRs1, IRs2, IRd;

  logic               ORegWrite, OALUSrc, OMemWrite, OMemRead, ORegStore;
  logic [ALUOP_W-1:0] OALUOP;
  logic [DATA_W-1:0]  OPCP2, O1stArg, O2ndArg, O3rdArg, OImm, ORs1, ORs2, ORd;

  modport master (
    output RegWrite,
    output IRegWrite, IALUSrc, IMemWrite, IMemRead, IRegStore, IALUOP,
    output IPCP2, I1stArg, I2ndArg, I3rdArg, IImm, IRs1, IRs2, IRd,
    input  ORegWrite, OALUSrc, OMemWrite, OMemRead, ORegStore, OALUOP,
    input  OPCP2, O1stArg, O2ndArg, O3rdArg, OImm, ORs1, ORs2, ORd
  );

  modport slave (
    input  RegWrite,
    input  IRegWrite, IALUSrc, IMemWrite, IMemRead, IRegStore, IALUOP,
    input  IPCP2, I1stArg, I2ndArg, I3rdArg, IImm, IRs1, IRs2, IRd,
    output ORegWrite, OALUSrc, OMemWrite, OMemRead, ORegStore, OALUOP,
    output OPCP2, O1stArg, O2ndArg, O3rdArg, OImm, ORs1, ORs2, ORd
  );

endinterface

// File: rtl/id_ex_reg_pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
// Enabled flip-flop bank with asynchronous active-low clear.
//   CLK   : rising-edge clock
//   Reset : asynchronous active-low clear to RST_VAL
//   en    : 1 = load d, 0 = hold
//   d / q : WIDTH-bit data in / registered data out
// -----------------------------------------------------------------------------
module pipe_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage: async clear, otherwise load on enable or hold.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register. Every I* field is captured into its O* twin on a
// rising CLK edge while RegWrite=1 and held while RegWrite=0. Reset (async,
// active-low) forces every output to zero.
//   CLK   : rising-edge clock
//   Reset : asynchronous active-low clear
//   bus   : id_ex_reg_if.slave (RegWrite, I* inputs, O* outputs)
// Both field groups share one enable, so the record is always loaded or held
// as a whole.
// -----------------------------------------------------------------------------
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input  logic         CLK,
  input  logic         Reset,
  id_ex_reg_if.slave   bus
);

  ctrl_t ctrl_d, ctrl_q;
  data_t data_d, data_q;

  assign ctrl_d.reg_write = bus.IRegWrite;
  assign ctrl_d.alu_src   = bus.IALUSrc;
  assign ctrl_d.mem_write = bus.IMemWrite;
  assign ctrl_d.mem_read  = bus.IMemRead;
  assign ctrl_d.reg_store = bus.IRegStore;
  assign ctrl_d.alu_op    = bus.IALUOP;

  assign data_d.pc_p2 = bus.IPCP2;
  assign data_d.arg1  = bus.I1stArg;
  assign data_d.arg2  = bus.I2ndArg;
  assign data_d.arg3  = bus.I3rdArg;
  assign data_d.imm   = bus.IImm;
  assign data_d.rs1   = bus.IRs1;
  assign data_d.rs2   = bus.IRs2;
  assign data_d.rd    = bus.IRd;

  pipe_reg #(
    .WIDTH   (CTRL_W),
    .RST_VAL (CTRL_RST)
  ) u_ctrl (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (bus.RegWrite),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_reg #(
    .WIDTH   (DATA_REC_W),
    .RST_VAL (DREC_RST)
  ) u_data (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (bus.RegWrite),
    .d     (data_d),
    .q     (data_q)
  );

  // Outputs come straight from the flops: no input-to-output path.
  assign bus.ORegWrite = ctrl_q.reg_write;
  assign bus.OALUSrc   = ctrl_q.alu_src;
  assign bus.OMemWrite = ctrl_q.mem_write;
  assign bus.OMemRead  = ctrl_q.mem_read;
  assign bus.ORegStore = ctrl_q.reg_store;
  assign bus.OALUOP    = ctrl_q.alu_op;

  assign bus.OPCP2   = data_q.pc_p2;
  assign bus.O1stArg = data_q.arg1;
  assign bus.O2ndArg = data_q.arg2;
  assign bus.O3rdArg = data_q.arg3;
  assign bus.OImm    = data_q.imm;
  assign bus.ORs1    = data_q.rs1;
  assign bus.ORs2    = data_q.rs2;
  assign bus.ORd     = data_q.rd;

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
// Self-checking bench for id_ex_reg. Expected records are queued when the
// stimulus is applied and popped after the capturing edge.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

  typedef struct packed {
    logic        rw;
    logic        alusrc;
    logic        mw;
    logic        mr;
    logic        rs;
    logic [2:0]  aluop;
    logic [15:0] pcp2;
    logic [15:0] a1;
    logic [15:0] a2;
    logic [15:0] a3;
    logic [15:0] imm;
    logic [15:0] rs1;
    logic [15:0] rs2;
    logic [15:0] rd;
  } rec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rec_t zero_rec = '0;
  rec_t cur_in;     // what is currently on the inputs
  rec_t model;      // what the outputs should hold right now
  rec_t sb_q[$];    // scoreboard of pending loads

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic apply_in(input rec_t r, input logic we);
    cur_in          = r;
    bus.RegWrite    = we;
    bus.IRegWrite   = r.rw;
    bus.IALUSrc     = r.alusrc;
    bus.IMemWrite   = r.mw;
    bus.IMemRead    = r.mr;
    bus.IRegStore   = r.rs;
    bus.IALUOP      = r.aluop;
    bus.IPCP2       = r.pcp2;
    bus.I1stArg     = r.a1;
    bus.I2ndArg     = r.a2;
    bus.I3rdArg     = r.a3;
    bus.IImm        = r.imm;
    bus.IRs1        = r.rs1;
    bus.IRs2        = r.rs2;
    bus.IRd         = r.rd;
  endtask

  task automatic sample_out(output rec_t r);
    r.rw     = bus.ORegWrite;
    r.alusrc = bus.OALUSrc;
    r.mw     = bus.OMemWrite;
    r.mr     = bus.OMemRead;
    r.rs     = bus.ORegStore;
    r.aluop  = bus.OALUOP;
    r.pcp2   = bus.OPCP2;
    r.a1     = bus.O1stArg;
    r.a2     = bus.O2ndArg;
    r.a3     = bus.O3rdArg;
    r.imm    = bus.OImm;
    r.rs1    = bus.ORs1;
    r.rs2    = bus.ORs2;
    r.rd     = bus.ORd;
  endtask

  function automatic rec_t rand_rec();
    rec_t r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r;
  endfunction

  // All-ones inputs while held in reset with the clock running.
  task automatic test_reset();
    rec_t got;
    #1 reset = 1'b0;
    apply_in('1, 1'b1);
    #1 sample_out(got);
    total++;
    if (got !== zero_rec) begin
      bad++;
      $display("FAIL reset_initial got=%h exp=%h", got, zero_rec);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sample_out(got);
      total++;
      if (got !== zero_rec) begin
        bad++;
        $display("FAIL reset_clocked[%0d] got=%h exp=%h", i, got, zero_rec);
      end
    end
    model = zero_rec;
  endtask

  // Single directed load; outputs must not move before the edge.
  task automatic test_load();
    rec_t got, exp_r;
    @(negedge clk);
    reset = 1'b1;
    exp_r = zero_rec;
    exp_r.pcp2  = 16'h0012;
    exp_r.a1    = 16'hA5A5;
    exp_r.imm   = 16'hFFF0;
    exp_r.aluop = 3'b101;
    exp_r.mr    = 1'b1;
    apply_in(exp_r, 1'b1);
    sb_q.push_back(exp_r);
    #1 sample_out(got);
    total++;
    if (got !== zero_rec) begin
      bad++;
      $display("FAIL load_before_edge got=%h exp=%h", got, zero_rec);
    end
    @(posedge clk); #1;
    model = sb_q.pop_front();
    sample_out(got);
    total++;
    if (got !== model) begin
      bad++;
      $display("FAIL load_after_edge got=%h exp=%h", got, model);
    end
    total++;
    if (bus.OALUOP !== 3'b101 || bus.OPCP2 !== 16'h0012) begin
      bad++;
      $display("FAIL load_fields got=%h/%h exp=5/0012", bus.OALUOP, bus.OPCP2);
    end
  endtask

  // Stall holds the record for several edges, then loads the new value.
  task automatic test_stall();
    rec_t got, nxt;
    @(negedge clk);
    nxt = cur_in;
    nxt.a2 = 16'h1234;
    apply_in(nxt, 1'b1);
    sb_q.push_back(nxt);
    @(posedge clk); #1;
    model = sb_q.pop_front();
    sample_out(got);
    total++;
    if (got !== model) begin
      bad++;
      $display("FAIL stall_preload got=%h exp=%h", got, model);
    end
    @(negedge clk);
    nxt = cur_in;
    nxt.a2 = 16'h5678;
    nxt.rd = 16'hBEEF;
    apply_in(nxt, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sample_out(got);
      total++;
      if (got !== model || got.a2 !== 16'h1234) begin
        bad++;
        $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, model);
      end
    end
    @(negedge clk);
    apply_in(cur_in, 1'b1);
    sb_q.push_back(cur_in);
    @(posedge clk); #1;
    model = sb_q.pop_front();
    sample_out(got);
    total++;
    if (got !== model || got.a2 !== 16'h5678) begin
      bad++;
      $display("FAIL stall_release got=%h exp=%h", got, model);
    end
  endtask

  // Mid-cycle input wiggles must not reach the outputs.
  task automatic test_input_change();
    rec_t got;
    @(negedge clk);
    apply_in(rand_rec(), 1'b1);
    #1 apply_in(rand_rec(), 1'b0);
    #1 sample_out(got);
    total++;
    if (got !== model) begin
      bad++;
      $display("FAIL input_change got=%h exp=%h", got, model);
    end
    @(posedge clk); #1;
    sample_out(got);
    total++;
    if (got !== model) begin
      bad++;
      $display("FAIL input_change_edge got=%h exp=%h", got, model);
    end
  endtask

  // IRd = 1,2,3 on consecutive edges; ORd lags by exactly one edge.
  task automatic test_back_to_back();
    rec_t got, nxt;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      nxt = cur_in;
      nxt.rd = 16'(i);
      apply_in(nxt, 1'b1);
      sb_q.push_back(nxt);
      #1 sample_out(got);
      total++;
      if (got.rd !== model.rd) begin
        bad++;
        $display("FAIL b2b_pre[%0d] got=%h exp=%h", i, got.rd, model.rd);
      end
      @(posedge clk); #1;
      model = sb_q.pop_front();
      sample_out(got);
      total++;
      if (got !== model || got.rd !== 16'(i)) begin
        bad++;
        $display("FAIL b2b_post[%0d] got=%h exp=%h", i, got, model);
      end
    end
  endtask

  // Random loads and stalls against the scoreboard.
  task automatic test_random();
    rec_t got, r;
    logic we;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r  = rand_rec();
      we = 1'($urandom_range(0, 1));
      apply_in(r, we);
      if (we) sb_q.push_back(r);
      @(posedge clk); #1;
      if (we) model = sb_q.pop_front();
      sample_out(got);
      total++;
      if (got !== model) begin
        bad++;
        $display("FAIL random[%0d] we=%0b got=%h exp=%h", i, we, got, model);
      end
    end
  endtask

  // Async clear mid-cycle during a stall, then release behaviour.
  task automatic test_async_reset();
    rec_t got, r;
    @(negedge clk);
    r = rand_rec();
    r.rs1 = 16'hCAFE;
    apply_in(r, 1'b1);
    sb_q.push_back(r);
    @(posedge clk); #1;
    model = sb_q.pop_front();
    @(negedge clk);
    apply_in(cur_in, 1'b0);
    #1 reset = 1'b0;
    #1 sample_out(got);
    total++;
    if (got !== zero_rec) begin
      bad++;
      $display("FAIL async_clear got=%h exp=%h", got, zero_rec);
    end
    model = zero_rec;
    @(posedge clk); #1;
    // Release with RegWrite=0: first edge must leave outputs at zero.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    sample_out(got);
    total++;
    if (got !== zero_rec) begin
      bad++;
      $display("FAIL release_stall got=%h exp=%h", got, zero_rec);
    end
    // Release with RegWrite=1 and IRs1=7.
    @(negedge clk);
    reset = 1'b0;
    r = zero_rec;
    r.rs1 = 16'h0007;
    apply_in(r, 1'b1);
    #1 reset = 1'b1;
    sb_q.push_back(r);
    #1 sample_out(got);
    total++;
    if (got.rs1 !== 16'h0000) begin
      bad++;
      $display("FAIL release_pre_edge got=%h exp=0000", got.rs1);
    end
    @(posedge clk); #1;
    model = sb_q.pop_front();
    sample_out(got);
    total++;
    if (got !== model || got.rs1 !== 16'h0007) begin
      bad++;
      $display("FAIL release_load got=%h exp=%h", got, model);
    end
  endtask

  initial begin
    apply_in(zero_rec, 1'b0);
    model = zero_rec;
    test_reset();
    test_load();
    test_stall();
    test_input_change();
    test_back_to_back();
    test_random();
    test_async_reset();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset: CLK and Reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low; 0 clears all outputs.
REQ-004 RegWrite  input  1  stage load enable; 1 = capture inputs, 0 = hold (stall).
REQ-005 IRegWrite, IALUSrc, IMemWrite, IMemRead, IRegStore  input  1 each  ID-stage control bits: register-file write, ALU B-source select, memory write, memory read, register store.
REQ-006 IALUOP  input  3  ALU operation code.
REQ-007 IPCP2  input  16  PC+2 of the instruction.
REQ-008 I1stArg, I2ndArg, I3rdArg  input  16 each  operand values read in ID.
REQ-009 IImm  input  16  sign-extended immediate.
REQ-010 IRs1, IRs2, IRd  input  16 each  source/destination register specifiers, zero-extended.
REQ-011 ORegWrite, OALUSrc, OMemWrite, OMemRead, ORegStore  output  1 each  registered copies of the matching I* bits.
REQ-012 OALUOP  output  3; OPCP2, O1stArg, O2ndArg, O3rdArg, OImm, ORs1, ORs2, ORd  output  16 each; registered copies of the matching I* inputs.

Function
REQ-013 On a rising CLK edge with Reset=1 and RegWrite=1, every O* output SHALL take the value its I* input had at that edge.
REQ-014 On a rising CLK edge with Reset=1 and RegWrite=0, every O* output SHALL keep its previous value.
REQ-015 Latency SHALL be exactly one clock edge from input to output; no combinational path from any input to any output.
REQ-016 All fields SHALL be loaded or held together as one record; no partial updates.
REQ-017 Values SHALL pass unmodified; no width conversion, sign change or decoding.
REQ-018 Input changes between edges SHALL have no effect on outputs.

Reset
REQ-019 While Reset=0, all outputs SHALL be 0 (1-bit outputs 1'b0, OALUOP 3'b000, 16-bit outputs 16'h0000), independent of CLK and RegWrite.
REQ-020 Reset assertion SHALL clear outputs immediately, with no clock edge required, including mid-operation or during a stall.
REQ-021 After Reset returns to 1, the first rising edge with RegWrite=1 SHALL load inputs normally; with RegWrite=0 the outputs SHALL stay 0.

Structure
REQ-022 A shared package SHALL define DATA_W=16, ALUOP_W=3 and the all-zero reset constants.
REQ-023 The module SHALL be built from one parameterized sub-module, pipe_reg (parameter WIDTH; ports CLK, Reset, en, d, q), which is an enabled flip-flop bank with asynchronous active-low clear, instantiated per field or per field group.

Verification
REQ-024 Reset=0 with all inputs at 16'hFFFF/1, RegWrite=1, clock toggling -> all outputs remain 0.
REQ-025 Reset=1, RegWrite=1, IPCP2=16'h0012, I1stArg=16'hA5A5, IImm=16'hFFF0, IALUOP=3'b101, IMemRead=1, then one edge -> OPCP2=16'h0012, O1stArg=16'hA5A5, OImm=16'hFFF0, OALUOP=3'b101, OMemRead=1; outputs unchanged before the edge.
REQ-026 After loading 16'h1234 into I2ndArg, set RegWrite=0, change I2ndArg to 16'h5678, clock 3 edges -> O2ndArg stays 16'h1234; set RegWrite=1, one edge -> 16'h5678.
REQ-027 Outputs loaded with nonzero values; drop Reset to 0 midway between edges -> all outputs read 0 before the next edge.
REQ-028 Back-to-back loads with RegWrite=1: IRd=1,2,3 on successive edges -> ORd=1,2,3 each lagging by one edge.
REQ-029 Release Reset with RegWrite=1 and IRs1=16'h0007 -> ORs1=0 until the first rising edge, then 16'h0007.
